remote_comm: RTL and testbench

Host-side command link for the knight robot. Accepts a 16-bit command on a single-cycle `snd_cmd` strobe and serializes it over UART TX as two 8N1 frames, high byte first, then `cmd_snt`. Independently receives the robot's 8-bit response on RX and presents it as `resp`/`resp_rdy`. It sits directly upstream of the robot's UART wrapper, and is what the bench's `send_RCOM_command` drives.

---
 rtl/remote_comm_if.sv | 28 ++
 rtl/remote_comm.sv | 190 +++++++++++++++++++
 tb/tb_remote_comm.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/remote_comm_if.sv
// remote_comm_if
//   Host-side command/response handshake bundle for remote_comm.
//   master : the host (drives snd_cmd, cmd, clr_resp_rdy)
//   slave  : remote_comm (drives cmd_snt, resp, resp_rdy)
//   snd_cmd       1   one-cycle strobe, cmd sampled on the same edge
//   cmd           16  command word, [15:8] sent first
//   clr_resp_rdy  1   clears resp_rdy
//   cmd_snt       1   both bytes shifted out; held until next accepted command
//   resp          8   last good received byte
//   resp_rdy      1   resp holds an unread byte
interface remote_comm_if;
  logic        snd_cmd;
  logic [15:0] cmd;
  logic        clr_resp_rdy;
  logic        cmd_snt;
  logic [7:0]  resp;
  logic        resp_rdy;

  modport master (
    output snd_cmd, cmd, clr_resp_rdy,
    input  cmd_snt, resp, resp_rdy
  );

  modport slave (
    input  snd_cmd, cmd, clr_resp_rdy,
    output cmd_snt, resp, resp_rdy
  );
endinterface

// File: rtl/remote_comm.sv
// remote_comm
//   Host-side UART command link. A 16-bit command accepted on snd_cmd is sent
//   as two 8N1 frames (high byte first) on TX, then cmd_snt is raised. An
//   independent receiver decodes 8N1 bytes from RX into resp/resp_rdy.
//   Ports:
//     clk    in   system clock
//     rst_n  in   asynchronous active-low reset
//     bus    slave side of remote_comm_if (snd_cmd, cmd, clr_resp_rdy,
//            cmd_snt, resp, resp_rdy)
//     RX     in   serial input from the robot, asynchronous, idles high
//     TX     out  serial output to the robot, idles high
//   BAUD_DIV: clk cycles per UART bit (minimum 4).
module remote_comm #(
  parameter int BAUD_DIV = 2604
) (
  input  logic          clk,
  input  logic          rst_n,
  remote_comm_if.slave  bus,
  input  logic          RX,
  output logic          TX
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // ---------------------------------------------------------------- transmit
  typedef enum logic [1:0] {TX_IDLE, TX_HIGH, TX_LOW} tx_state_t;

  tx_state_t        tx_state_reg;
  logic [9:0]       tx_shift_reg;
  logic [CNT_W-1:0] tx_baud_reg;
  logic [3:0]       tx_bit_reg;
  // Only the low byte has to survive past acceptance; the high byte goes
  // straight into the shift register on the accepting edge.
  logic [7:0]       cmd_lo_reg;
  logic             cmd_snt_reg;

  logic cmd_accept;
  logic tx_bit_end;

  assign cmd_accept = (tx_state_reg == TX_IDLE) && bus.snd_cmd;
  assign tx_bit_end = (tx_baud_reg == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_reg <= TX_IDLE;
      tx_shift_reg <= '1;
      tx_baud_reg  <= '0;
      tx_bit_reg   <= '0;
      cmd_lo_reg   <= '0;
      cmd_snt_reg  <= 1'b0;
    end else begin
      case (tx_state_reg)
        TX_IDLE: begin
          if (bus.snd_cmd) begin
            cmd_lo_reg   <= bus.cmd[7:0];
            cmd_snt_reg  <= 1'b0;
            tx_shift_reg <= {1'b1, bus.cmd[15:8], 1'b0};
            tx_baud_reg  <= '0;
            tx_bit_reg   <= '0;
            tx_state_reg <= TX_HIGH;
          end
        end
        TX_HIGH, TX_LOW: begin
          if (tx_bit_end) begin
            tx_baud_reg <= '0;
            if (tx_bit_reg == 4'd9) begin
              // Stop bit finished: chain the low byte with no idle gap, or
              // finish the command.
              tx_bit_reg <= '0;
              if (tx_state_reg == TX_HIGH) begin
                tx_shift_reg <= {1'b1, cmd_lo_reg, 1'b0};
                tx_state_reg <= TX_LOW;
              end else begin
                tx_shift_reg <= '1;
                cmd_snt_reg  <= 1'b1;
                tx_state_reg <= TX_IDLE;
              end
            end else begin
              tx_shift_reg <= {1'b1, tx_shift_reg[9:1]};
              tx_bit_reg   <= tx_bit_reg + 4'd1;
            end
          end else begin
            tx_baud_reg <= tx_baud_reg + CNT_ONE;
          end
        end
        default: tx_state_reg <= TX_IDLE;
      endcase
    end
  end

  assign TX          = tx_shift_reg[0];
  assign bus.cmd_snt = cmd_snt_reg;

  // ----------------------------------------------------------------- receive
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic             rx_meta_reg;
  logic             rx_sync_reg;
  logic             rx_prev_reg;
  rx_state_t        rx_state_reg;
  logic [CNT_W-1:0] rx_baud_reg;
  logic [2:0]       rx_bit_reg;
  logic [7:0]       rx_shift_reg;
  // Set after a bad stop bit: wait for the line to go idle before re-arming.
  logic             rx_ferr_reg;
  logic [7:0]       resp_reg;
  logic             resp_rdy_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_reg  <= 1'b1;
      rx_sync_reg  <= 1'b1;
      rx_prev_reg  <= 1'b1;
      rx_state_reg <= RX_IDLE;
      rx_baud_reg  <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
      rx_ferr_reg  <= 1'b0;
      resp_reg     <= '0;
      resp_rdy_reg <= 1'b0;
    end else begin
      rx_meta_reg <= RX;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;

      // Clear first; a good stop bit later in this block overrides it.
      if (bus.clr_resp_rdy || cmd_accept) begin
        resp_rdy_reg <= 1'b0;
      end

      case (rx_state_reg)
        RX_IDLE: begin
          if (!rx_sync_reg && rx_prev_reg) begin
            rx_baud_reg  <= '0;
            rx_state_reg <= RX_START;
          end
        end
        RX_START: begin
          if (rx_baud_reg == HALF_LAST) begin
            rx_baud_reg <= '0;
            rx_bit_reg  <= '0;
            // Line back high at mid start bit means a glitch, not a frame.
            rx_state_reg <= rx_sync_reg ? RX_IDLE : RX_DATA;
          end else begin
            rx_baud_reg <= rx_baud_reg + CNT_ONE;
          end
        end
        RX_DATA: begin
          if (rx_baud_reg == BAUD_LAST) begin
            rx_baud_reg  <= '0;
            rx_shift_reg <= {rx_sync_reg, rx_shift_reg[7:1]};
            rx_bit_reg   <= rx_bit_reg + 3'd1;
            if (rx_bit_reg == 3'd7) begin
              rx_state_reg <= RX_STOP;
            end
          end else begin
            rx_baud_reg <= rx_baud_reg + CNT_ONE;
          end
        end
        RX_STOP: begin
          if (rx_ferr_reg) begin
            if (rx_sync_reg) begin
              rx_ferr_reg  <= 1'b0;
              rx_state_reg <= RX_IDLE;
            end
          end else if (rx_baud_reg == BAUD_LAST) begin
            rx_baud_reg <= '0;
            if (rx_sync_reg) begin
              resp_reg     <= rx_shift_reg;
              resp_rdy_reg <= 1'b1;
              rx_state_reg <= RX_IDLE;
            end else begin
              rx_ferr_reg <= 1'b1;
            end
          end else begin
            rx_baud_reg <= rx_baud_reg + CNT_ONE;
          end
        end
        default: rx_state_reg <= RX_IDLE;
      endcase
    end
  end

  assign bus.resp     = resp_reg;
  assign bus.resp_rdy = resp_rdy_reg;

endmodule

// File: tb/tb_remote_comm.sv
// tb_remote_comm
//   Self-checking bench for remote_comm with BAUD_DIV=16. A reference model
//   decides which strobes are accepted and what bytes/timing must appear; a
//   line decoder turns TX back into bytes; an RX driver builds 8N1 frames.
module tb_remote_comm;
  localparam int BD = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic RX = 1'b1;
  logic TX;

  remote_comm_if bus();

  remote_comm #(.BAUD_DIV(BD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .RX    (RX),
    .TX    (TX)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------- reference model
  bit         model_has_prev = 0;
  int         model_last_acc = 0;
  logic [7:0] exp_q[$];
  int         exp_snt_cyc = 0;
  logic [7:0] exp_resp = 8'h00;

  // ---------------------------------------------------------------- monitors
  logic [7:0] got_q[$];
  int         tx_start_q[$];
  bit         mon_busy = 0;
  int         mon_t = 0;
  int         mon_start = 0;
  logic [9:0] mon_bits = '0;

  // TX line decoder: sample every bit at its centre.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      mon_busy = 0;
    end else if (!mon_busy) begin
      if (TX === 1'b0) begin
        mon_busy  = 1;
        mon_t     = 0;
        mon_start = cyc;
      end
    end else begin
      mon_t++;
      if (mon_t % BD == BD / 2) begin
        mon_bits[mon_t / BD] = TX;
        if (mon_t / BD == 9) begin
          check("tx_start_bit", {31'd0, mon_bits[0]}, 0);
          check("tx_stop_bit", {31'd0, mon_bits[9]}, 1);
          got_q.push_back(mon_bits[8:1]);
          tx_start_q.push_back(mon_start);
          $display("tx frame byte=0x%h start_cyc=%0d", mon_bits[8:1], mon_start);
          mon_busy = 0;
        end
      end
    end
  end

  bit snt_prev = 0, snt_seen = 0;
  int snt_rise_cyc = 0;
  bit rdy_prev = 0, rdy_seen = 0;
  int rdy_rise_cyc = 0;

  initial forever begin
    @(negedge clk);
    if (bus.cmd_snt === 1'b1 && !snt_prev) begin
      snt_seen = 1;
      snt_rise_cyc = cyc;
    end
    snt_prev = (bus.cmd_snt === 1'b1);
    if (bus.resp_rdy === 1'b1 && !rdy_prev) begin
      rdy_seen = 1;
      rdy_rise_cyc = cyc;
    end
    rdy_prev = (bus.resp_rdy === 1'b1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------------- tasks
  // Strobe snd_cmd so the DUT samples it on rising edge number edge_c.
  task automatic pulse_at(int edge_c, logic [15:0] v);
    bit acc;
    while (cyc < edge_c - 1) @(negedge clk);
    bus.snd_cmd = 1'b1;
    bus.cmd     = v;
    // Only an idle link accepts; it is idle from one edge after completion.
    acc = !model_has_prev || (edge_c >= model_last_acc + 20 * BD + 1);
    if (acc) begin
      model_has_prev = 1;
      model_last_acc = edge_c;
      exp_q.push_back(v[15:8]);
      exp_q.push_back(v[7:0]);
      exp_snt_cyc = edge_c + 20 * BD;
      snt_seen = 0;
    end
    $display("cmd 0x%h edge=%0d accepted=%0d", v, edge_c, acc);
    @(negedge clk);
    bus.snd_cmd = 1'b0;
  endtask

  int rx_drive_cyc = 0;

  task automatic rx_frame(logic [7:0] b, bit stop_b);
    logic [9:0] fr;
    fr = {stop_b, b, 1'b0};
    rdy_seen = 0;
    rx_drive_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      RX = fr[i];
      repeat (BD) @(negedge clk);
    end
    RX = 1'b1;
    $display("rx frame byte=0x%h stop=%0d drive_cyc=%0d", b, stop_b, rx_drive_cyc);
  endtask

  // The line falls before edge D+1; the synchroniser makes it visible to the
  // receiver at edge D+3 (S); the stop sample lands at S + BD/2 + 9*BD.
  task automatic check_rx(bit good, logic [7:0] b);
    if (good) begin
      check("rx_rdy_seen", {31'd0, rdy_seen}, 1);
      check("rx_rdy_time", rdy_rise_cyc, rx_drive_cyc + 3 + BD / 2 + 9 * BD);
      exp_resp = b;
    end else begin
      check("rx_ferr_no_rdy", {31'd0, rdy_seen}, 0);
    end
    check("rx_resp", {24'd0, bus.resp}, {24'd0, exp_resp});
  endtask

  task automatic clr_rdy();
    bus.clr_resp_rdy = 1'b1;
    @(negedge clk);
    bus.clr_resp_rdy = 1'b0;
    check("clr_rdy", {31'd0, bus.resp_rdy}, 0);
  endtask

  task automatic wait_snt();
    for (int i = 0; i < 2000 && !snt_seen; i++) @(negedge clk);
    check("snt_seen", {31'd0, snt_seen}, 1);
    check("snt_time", snt_rise_cyc, exp_snt_cyc);
  endtask

  task automatic drain_tx();
    check("tx_count", got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] g, x;
      g = got_q.pop_front();
      x = exp_q.pop_front();
      check("tx_byte", {24'd0, g}, {24'd0, x});
    end
    got_q.delete();
    exp_q.delete();
    tx_start_q.delete();
  endtask

  // -------------------------------------------------------------------- main
  int e;
  int s0, s1;
  logic [15:0] rv;
  logic [7:0]  rb;
  bit          rstop;
  int          roff, rdel;

  initial begin
    bus.snd_cmd = 1'b0;
    bus.cmd = '0;
    bus.clr_resp_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, TX}, 1);
    check("rst_cmd_snt", {31'd0, bus.cmd_snt}, 0);
    check("rst_resp", {24'd0, bus.resp}, 0);
    check("rst_resp_rdy", {31'd0, bus.resp_rdy}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic send and frame timing.
    e = cyc + 1;
    pulse_at(e, 16'h29C3);
    check("tx_falls_e0", {31'd0, TX}, 0);
    wait_snt();
    s0 = (tx_start_q.size() > 0) ? tx_start_q[0] : -1;
    s1 = (tx_start_q.size() > 1) ? tx_start_q[1] : -1;
    check("frame0_start", s0, e);
    check("frame1_start", s1, e + 10 * BD);
    drain_tx();
    repeat (20) @(negedge clk);
    check("snt_held", {31'd0, bus.cmd_snt}, 1);

    // Strobes while busy and on the completion edge are ignored; the next
    // edge accepts.
    e = cyc + 1;
    pulse_at(e, 16'h1234);
    pulse_at(e + 50, 16'hFFFF);
    pulse_at(e + 200, 16'hFFFF);
    pulse_at(e + 20 * BD, 16'hFFFF);
    check("busy_snt_seen", {31'd0, snt_seen}, 1);
    check("busy_snt_time", snt_rise_cyc, e + 20 * BD);
    check("busy_snt_level", {31'd0, bus.cmd_snt}, 1);
    pulse_at(e + 20 * BD + 1, 16'h5A96);
    check("snt_cleared", {31'd0, bus.cmd_snt}, 0);
    wait_snt();
    drain_tx();

    // Response receive and clear.
    repeat (5) @(negedge clk);
    rx_frame(8'hA5, 1'b1);
    check_rx(1'b1, 8'hA5);
    clr_rdy();
    check("resp_after_clr", {24'd0, bus.resp}, 32'hA5);

    // Framing error, glitch, then good byte; then an overrun.
    repeat (5) @(negedge clk);
    rx_frame(8'h3C, 1'b0);
    check_rx(1'b0, 8'h3C);
    repeat (10) @(negedge clk);
    rdy_seen = 0;
    RX = 1'b0;
    repeat (4) @(negedge clk);
    RX = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_no_rdy", {31'd0, rdy_seen}, 0);
    check("glitch_resp", {24'd0, bus.resp}, 32'hA5);
    rx_frame(8'h5A, 1'b1);
    check_rx(1'b1, 8'h5A);
    repeat (5) @(negedge clk);
    rx_frame(8'h66, 1'b1);
    check("overrun_resp", {24'd0, bus.resp}, 32'h66);
    check("overrun_rdy", {31'd0, bus.resp_rdy}, 1);
    exp_resp = 8'h66;
    clr_rdy();

    // Reset in the middle of a frame (TX is low at that point).
    e = cyc + 1;
    pulse_at(e, 16'h817E);
    while (cyc < e + 99) @(negedge clk);
    check("pre_rst_tx_low", {31'd0, TX}, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx", {31'd0, TX}, 1);
    check("mid_rst_cmd_snt", {31'd0, bus.cmd_snt}, 0);
    check("mid_rst_resp", {24'd0, bus.resp}, 0);
    got_q.delete();
    exp_q.delete();
    tx_start_q.delete();
    model_has_prev = 0;
    exp_resp = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    e = cyc + 1;
    pulse_at(e, 16'hBEEF);
    wait_snt();
    drain_tx();

    // Full duplex.
    fork
      pulse_at(cyc + 1, 16'h0F0F);
      begin
        repeat (40) @(negedge clk);
        rx_frame(8'hC7, 1'b1);
      end
    join
    check_rx(1'b1, 8'hC7);
    wait_snt();
    drain_tx();

    // Randomised: command plus one stray strobe, concurrent RX frame.
    for (int it = 0; it < 6; it++) begin
      rv    = 16'($urandom);
      rb    = 8'($urandom);
      rstop = ($urandom_range(0, 3) != 0);
      roff  = int'($urandom_range(1, 20 * BD));
      rdel  = int'($urandom_range(0, 120));
      clr_rdy();
      fork
        begin
          int e1;
          e1 = cyc + 1;
          pulse_at(e1, rv);
          pulse_at(e1 + roff, 16'($urandom));
        end
        begin
          repeat (rdel) @(negedge clk);
          rx_frame(rb, rstop);
        end
      join
      check_rx(rstop, rb);
      wait_snt();
      drain_tx();
      repeat (30) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
